// File: rtl/matrix_pkg.sv
// Shared types and derived sizes for the matrix DMA controller.
package matrix_pkg;

  localparam int unsigned DEFAULT_DIM    = 5;
  localparam int unsigned DEFAULT_ELEM_W = 8;
  localparam int unsigned DEFAULT_N      = DEFAULT_DIM * DEFAULT_DIM;
  localparam int unsigned DEFAULT_MAT_W  = DEFAULT_N * DEFAULT_ELEM_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Packed width of a dim x dim matrix of elem_w-bit elements.
  function automatic int unsigned mat_width(input int unsigned dim, input int unsigned elem_w);
    return dim * dim * elem_w;
  endfunction

endpackage

// File: rtl/matrix_dma_controller_mem_read_pipe.sv
// Read address generator with a valid-tag pipeline matching the RAM read latency.
module mem_read_pipe
  import matrix_pkg::*;
#(
  parameter int unsigned N       = DEFAULT_N,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned IDX_W   = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              capture_en,
  output logic [IDX_W-1:0]  capture_idx,
  output logic              capture_last
);

  logic               issue_q;
  logic [IDX_W-1:0]   issue_idx;
  logic [MEM_LAT-1:0] vld_sr;

  // Issue one read per cycle from base for N consecutive words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr   <= '0;
      issue_q   <= 1'b0;
      issue_idx <= '0;
    end else if (start) begin
      rd_addr   <= base;
      issue_q   <= 1'b1;
      issue_idx <= '0;
    end else if (issue_q) begin
      rd_addr   <= rd_addr + ADDR_W'(1);
      issue_idx <= issue_idx + IDX_W'(1);
      if (issue_idx == IDX_W'(N - 1)) issue_q <= 1'b0;
    end
  end

  // Tag each issued read; the tag emerges when its data is on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= issue_q;
      for (int unsigned k = 1; k < MEM_LAT; k++) vld_sr[k] <= vld_sr[k-1];
    end
  end

  // Element index for each returning word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capture_idx <= '0;
    end else if (start) begin
      capture_idx <= '0;
    end else if (capture_en) begin
      capture_idx <= capture_idx + IDX_W'(1);
    end
  end

  assign capture_en   = vld_sr[MEM_LAT-1];
  assign capture_last = capture_en && (capture_idx == IDX_W'(N - 1));

endmodule

// File: rtl/matrix_dma_controller.sv
// Loads two matrices from RAM into the coprocessor, runs it and writes the result back.
module matrix_dma_controller
  import matrix_pkg::*;
#(
  parameter int unsigned DIM     = DEFAULT_DIM,
  parameter int unsigned ELEM_W  = DEFAULT_ELEM_W,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned N      = DIM * DIM,
  localparam int unsigned MAT_W  = mat_width(DIM, ELEM_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [2:0]          op_code,
  input  logic [ADDR_W-1:0]   src_base,
  input  logic [ADDR_W-1:0]   dst_base,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wren,
  output logic [2*ELEM_W-1:0] mem_wdata,
  input  logic [2*ELEM_W-1:0] mem_rdata,
  output logic [2:0]          cp_op_code,
  output logic [MAT_W-1:0]    cp_matrix_a,
  output logic [MAT_W-1:0]    cp_matrix_b,
  output logic                cp_start,
  input  logic                cp_done,
  input  logic [MAT_W-1:0]    cp_result,
  input  logic                cp_overflow,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                overflow,
  output logic [2:0]          state_dbg
);

  localparam int unsigned IDX_W = $clog2(N + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_t             state_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [IDX_W-1:0]   wr_idx;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [MAT_W-1:0]   result_q;
  logic               accept;
  logic [ADDR_W-1:0]  rd_addr;
  logic               capture_en;
  logic [IDX_W-1:0]   capture_idx;
  logic               capture_last;

  assign accept    = go && (state_q == S_IDLE);
  assign mem_addr  = (state_q == S_WRITE) ? wr_addr_q : rd_addr;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  mem_read_pipe #(
    .N       (N),
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT),
    .IDX_W   (IDX_W)
  ) u_read_pipe (
    .clk          (clk),
    .reset        (reset),
    .start        (accept),
    .base         (src_base),
    .rd_addr      (rd_addr),
    .capture_en   (capture_en),
    .capture_idx  (capture_idx),
    .capture_last (capture_last)
  );

  // Split each returning word into its A (low) and B (high) element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cp_matrix_a <= '0;
      cp_matrix_b <= '0;
    end else if (capture_en) begin
      cp_matrix_a[int'(capture_idx)*ELEM_W +: ELEM_W] <= mem_rdata[ELEM_W-1:0];
      cp_matrix_b[int'(capture_idx)*ELEM_W +: ELEM_W] <= mem_rdata[2*ELEM_W-1:ELEM_W];
    end
  end

  // Sequencer: read, start, wait for done or timeout, write back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dst_q      <= '0;
      wr_addr_q  <= '0;
      wr_idx     <= '0;
      tmo_cnt    <= '0;
      result_q   <= '0;
      cp_op_code <= '0;
      cp_start   <= 1'b0;
      mem_wren   <= 1'b0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cp_start <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            cp_op_code <= op_code;
            dst_q      <= dst_base;
            error      <= 1'b0;
            overflow   <= 1'b0;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          if (capture_last) begin
            cp_start <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          tmo_cnt <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Element 0 goes out straight from cp_result so the first write
          // lands on the first WRITE cycle.
          if (cp_done) begin
            result_q  <= cp_result;
            overflow  <= cp_overflow;
            wr_addr_q <= dst_q;
            wr_idx    <= '0;
            mem_wren  <= 1'b1;
            mem_wdata <= {{ELEM_W{1'b0}}, cp_result[ELEM_W-1:0]};
            state_q   <= S_WRITE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            error   <= 1'b1;
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_WRITE: begin
          if (wr_idx == IDX_W'(N)) begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end else if (wr_idx == IDX_W'(N - 1)) begin
            mem_wren <= 1'b0;
            wr_idx   <= wr_idx + IDX_W'(1);
          end else begin
            wr_idx    <= wr_idx + IDX_W'(1);
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            mem_wdata <= {{ELEM_W{1'b0}}, result_q[(int'(wr_idx) + 1)*ELEM_W +: ELEM_W]};
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_dma_controller.sv
// Directed bench: one controller at read latency 2 plus two at latency 1 and 3.
module tb_matrix_dma_controller;
  import matrix_pkg::*;

  localparam int unsigned N  = DEFAULT_N;
  localparam int unsigned MW = DEFAULT_MAT_W;
  localparam int          NI = 3;

  logic clk;
  logic reset;

  logic          go_v    [NI];
  logic [2:0]    op_v    [NI];
  logic [6:0]    src_v   [NI];
  logic [6:0]    dst_v   [NI];
  logic [6:0]    addr_v  [NI];
  logic          wren_v  [NI];
  logic [15:0]   wdata_v [NI];
  logic [15:0]   rdata_v [NI];
  logic [2:0]    cpop_v  [NI];
  logic [MW-1:0] cpa_v   [NI];
  logic [MW-1:0] cpb_v   [NI];
  logic [MW-1:0] cpres_v [NI];
  logic          start_v [NI];
  logic          cpdone_v[NI];
  logic          cpov_v  [NI];
  logic          busy_v  [NI];
  logic          done_v  [NI];
  logic          err_v   [NI];
  logic          ov_v    [NI];
  logic [2:0]    st_v    [NI];

  logic [15:0] ram [128];
  logic        tb_we;
  logic [6:0]  tb_waddr;
  logic [15:0] tb_wdata;

  int unsigned cyc;
  int          n_start, n_done, n_wren;
  int          n_checks, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (wren_v[0]) ram[addr_v[0]] <= wdata_v[0];
  end

  always @(negedge clk) begin
    if (start_v[0]) n_start <= n_start + 1;
    if (done_v[0])  n_done  <= n_done + 1;
    if (wren_v[0])  n_wren  <= n_wren + 1;
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic [15:0] rpipe [LAT];

    always @(posedge clk) begin
      rpipe[0] <= ram[addr_v[g]];
      for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign rdata_v[g] = rpipe[LAT-1];

    matrix_dma_controller #(
      .DIM     (5),
      .ELEM_W  (8),
      .ADDR_W  (7),
      .MEM_LAT (LAT),
      .TIMEOUT (20)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .go          (go_v[g]),
      .op_code     (op_v[g]),
      .src_base    (src_v[g]),
      .dst_base    (dst_v[g]),
      .mem_addr    (addr_v[g]),
      .mem_wren    (wren_v[g]),
      .mem_wdata   (wdata_v[g]),
      .mem_rdata   (rdata_v[g]),
      .cp_op_code  (cpop_v[g]),
      .cp_matrix_a (cpa_v[g]),
      .cp_matrix_b (cpb_v[g]),
      .cp_start    (start_v[g]),
      .cp_done     (cpdone_v[g]),
      .cp_result   (cpres_v[g]),
      .cp_overflow (cpov_v[g]),
      .busy        (busy_v[g]),
      .done        (done_v[g]),
      .error       (err_v[g]),
      .overflow    (ov_v[g]),
      .state_dbg   (st_v[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] el(input logic [MW-1:0] m, input int i);
    return m[i*8 +: 8];
  endfunction

  task automatic ram_put(input logic [6:0] a, input logic [15:0] d);
    tb_waddr = a;
    tb_wdata = d;
    tb_we    = 1'b1;
    @(posedge clk); #1;
    tb_we    = 1'b0;
  endtask

  task automatic go0(input logic [6:0] s, input logic [6:0] d, input logic [2:0] op,
                     output int unsigned c);
    @(posedge clk); #1;
    go_v[0] = 1'b1; src_v[0] = s; dst_v[0] = d; op_v[0] = op;
    c = cyc;
    @(posedge clk); #1;
    go_v[0] = 1'b0;
  endtask

  // which: 0 = cp_start, 1 = done, 2 = mem_wren (instance 0)
  task automatic wait_for(input int which, input int limit, output int unsigned c);
    bit found;
    found = 1'b0;
    for (int k = 0; k < limit && !found; k++) begin
      @(negedge clk);
      found = (which == 0) ? start_v[0] : ((which == 1) ? done_v[0] : wren_v[0]);
    end
    c = cyc;
    check_eq($sformatf("wait_%0d", which), {31'b0, found}, 32'd1);
  endtask

  task automatic pulse_done(input int d, input logic [MW-1:0] res, input logic ov);
    @(posedge clk);
    repeat (d - 1) @(posedge clk);
    #1;
    cpdone_v[0] = 1'b1; cpres_v[0] = res; cpov_v[0] = ov;
    @(posedge clk); #1;
    cpdone_v[0] = 1'b0; cpov_v[0] = 1'b0;
  endtask

  initial begin
    int unsigned c_go, c_s, c_d;
    int s0, d0, w0;
    logic [MW-1:0] res;

    reset = 1'b0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    for (int g = 0; g < NI; g++) begin
      go_v[g] = 1'b0; op_v[g] = '0; src_v[g] = '0; dst_v[g] = '0;
      cpdone_v[g] = 1'b0; cpres_v[g] = '0; cpov_v[g] = 1'b0;
    end
    repeat (3) @(posedge clk); #1;

    // reset state
    check_eq("rst_state", {29'b0, st_v[0]}, 32'd0);
    check_eq("rst_busy", {31'b0, busy_v[0]}, 32'd0);
    check_eq("rst_done", {31'b0, done_v[0]}, 32'd0);
    check_eq("rst_err", {31'b0, err_v[0]}, 32'd0);
    check_eq("rst_wren", {31'b0, wren_v[0]}, 32'd0);
    check_eq("rst_start", {31'b0, start_v[0]}, 32'd0);
    check_eq("rst_mat_a", {31'b0, |cpa_v[0]}, 32'd0);
    reset = 1'b1;

    for (int a = 0; a < 128; a++)
      ram_put(7'(a), (a < 25) ? {8'd1, 8'(a + 1)} : 16'h0000);

    // basic load, ignored go during WAIT, writeback
    s0 = n_start; d0 = n_done; w0 = n_wren;
    go0(7'd0, 7'd64, 3'd5, c_go);
    wait_for(0, 100, c_s);
    check_eq("start_lat", c_s - c_go, 32'd28);
    for (int i = 0; i < int'(N); i++) begin
      check_eq($sformatf("load_a[%0d]", i), {24'b0, el(cpa_v[0], i)}, 32'(i + 1));
      check_eq($sformatf("load_b[%0d]", i), {24'b0, el(cpb_v[0], i)}, 32'd1);
    end
    check_eq("op_latch", {29'b0, cpop_v[0]}, 32'd5);
    for (int i = 0; i < int'(N); i++) res[i*8 +: 8] = 8'(2 * (i + 1));
    @(posedge clk); #1;
    go_v[0] = 1'b1; src_v[0] = 7'd50; dst_v[0] = 7'd100; op_v[0] = 3'd1;
    @(posedge clk); #1;
    go_v[0] = 1'b0;
    check_eq("wait_state", {29'b0, st_v[0]}, 32'd3);
    repeat (8) @(posedge clk); #1;
    cpdone_v[0] = 1'b1; cpres_v[0] = res; cpov_v[0] = 1'b0;
    @(posedge clk); #1;
    cpdone_v[0] = 1'b0;
    wait_for(1, 100, c_d);
    check_eq("done_lat", c_d - c_go, 32'd65);
    repeat (3) @(posedge clk); #1;
    check_eq("wb_starts", 32'(n_start - s0), 32'd1);
    check_eq("wb_dones", 32'(n_done - d0), 32'd1);
    check_eq("wb_wrens", 32'(n_wren - w0), 32'd25);
    check_eq("wb_err", {31'b0, err_v[0]}, 32'd0);
    check_eq("op_kept", {29'b0, cpop_v[0]}, 32'd5);
    check_eq("ignored_dst", {16'b0, ram[100]}, 32'd0);
    for (int i = 0; i < int'(N); i++)
      check_eq($sformatf("wb_ram[%0d]", i), {16'b0, ram[64 + i]}, 32'(2 * (i + 1)));

    // overflow, negative element, cp_done on the timeout limit cycle
    w0 = n_wren;
    go0(7'd0, 7'd64, 3'd2, c_go);
    wait_for(0, 100, c_s);
    for (int i = 0; i < int'(N); i++) res[i*8 +: 8] = 8'(i);
    res[7:0]  = 8'h80;
    res[15:8] = 8'hFF;
    pulse_done(20, res, 1'b1);
    wait_for(1, 100, c_d);
    check_eq("ov_ram0", {16'b0, ram[64]}, 32'h0080);
    check_eq("ov_ram1", {16'b0, ram[65]}, 32'h00FF);
    check_eq("ov_ram2", {16'b0, ram[66]}, 32'h0002);
    check_eq("ov_flag", {31'b0, ov_v[0]}, 32'd1);
    check_eq("limit_err", {31'b0, err_v[0]}, 32'd0);
    repeat (5) @(posedge clk); #1;
    check_eq("ov_wrens", 32'(n_wren - w0), 32'd25);
    check_eq("ov_held", {31'b0, ov_v[0]}, 32'd1);
    check_eq("idle_state", {29'b0, st_v[0]}, 32'd0);

    // timeout
    d0 = n_done; w0 = n_wren;
    go0(7'd0, 7'd32, 3'd1, c_go);
    check_eq("ov_cleared", {31'b0, ov_v[0]}, 32'd0);
    wait_for(0, 100, c_s);
    wait_for(1, 100, c_d);
    check_eq("tmo_lat", c_d - c_s, 32'd21);
    check_eq("tmo_err", {31'b0, err_v[0]}, 32'd1);
    repeat (3) @(posedge clk); #1;
    check_eq("tmo_wrens", 32'(n_wren - w0), 32'd0);
    check_eq("tmo_dones", 32'(n_done - d0), 32'd1);
    check_eq("tmo_sticky", {31'b0, err_v[0]}, 32'd1);

    // address wrap at three read latencies
    for (int i = 0; i < int'(N); i++)
      ram_put(7'(120 + i), {8'(100 + i), 8'(3 * i + 7)});
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) begin
      go_v[g] = 1'b1; src_v[g] = 7'd120; dst_v[g] = 7'd0; op_v[g] = 3'd0;
    end
    @(posedge clk); #1;
    for (int g = 0; g < NI; g++) go_v[g] = 1'b0;
    check_eq("err_cleared", {31'b0, err_v[0]}, 32'd0);
    repeat (34) @(posedge clk); #1;
    for (int g = 0; g < NI; g++) begin
      check_eq($sformatf("wrap_state%0d", g), {29'b0, st_v[g]}, 32'd3);
      for (int i = 0; i < int'(N); i++) begin
        check_eq($sformatf("wrap%0d_a[%0d]", g, i), {24'b0, el(cpa_v[g], i)}, 32'(3 * i + 7));
        check_eq($sformatf("wrap%0d_b[%0d]", g, i), {24'b0, el(cpb_v[g], i)}, 32'(100 + i));
      end
    end
    repeat (40) @(posedge clk); #1;
    for (int g = 0; g < NI; g++)
      check_eq($sformatf("wrap_idle%0d", g), {29'b0, st_v[g]}, 32'd0);

    // reset in the middle of WRITE
    go0(7'd0, 7'd64, 3'd3, c_go);
    wait_for(0, 100, c_s);
    pulse_done(1, res, 1'b1);
    wait_for(2, 100, c_d);
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_wren", {31'b0, wren_v[0]}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("arst_wren", {31'b0, wren_v[0]}, 32'd0);
    check_eq("arst_state", {29'b0, st_v[0]}, 32'd0);
    check_eq("arst_busy", {31'b0, busy_v[0]}, 32'd0);
    check_eq("arst_addr", {25'b0, addr_v[0]}, 32'd0);
    check_eq("arst_wdata", {16'b0, wdata_v[0]}, 32'd0);
    check_eq("arst_ov", {31'b0, ov_v[0]}, 32'd0);
    check_eq("arst_op", {29'b0, cpop_v[0]}, 32'd0);
    check_eq("arst_mat_a", {31'b0, |cpa_v[0]}, 32'd0);
    check_eq("arst_mat_b", {31'b0, |cpb_v[0]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
